// File: rtl/paddle_key_scheduler.sv
// Paddle key scheduler: decodes PS/2 set-2 scancodes for W/S/I/K into a
// held-key vector and turns the held state into rate-limited paddle move
// pulses, one per TICK_DIV frame ticks while a direction is held.
//
// Handshake: ps2_key_pressed is a valid-only strobe (no ready); every cycle
// it is high carries exactly one byte on ps2_key_data, which is consumed in
// that cycle. frame_tick is likewise a one-cycle strobe with no back-pressure.

// One paddle axis: resolves up/down/priority into a direction and paces
// move pulses against frame_tick.
module paddle_axis #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_frame_tick,
    input  logic i_up_held,
    input  logic i_down_held,
    input  logic i_pri_down,
    output logic o_up_pulse,
    output logic o_down_pulse
);

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    localparam logic [3:0] LP_LAST = 4'(TICK_DIV - 1);

    dir_t       w_dir;
    dir_t       r_prev_dir;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_eff;
    logic [3:0] w_cnt_next;
    logic       r_up_pulse;
    logic       r_down_pulse;

    // Direction from the currently registered held state; when both keys
    // are down the most recently made one wins.
    always_comb begin
        w_dir = DIR_NONE;
        if (i_up_held && !i_down_held) begin
            w_dir = DIR_UP;
        end else if (i_down_held && !i_up_held) begin
            w_dir = DIR_DOWN;
        end else if (i_up_held && i_down_held) begin
            w_dir = i_pri_down ? DIR_DOWN : DIR_UP;
        end
    end

    // A fresh direction (or none) restarts the cadence so the next tick moves.
    always_comb begin
        w_cnt_eff = r_cnt;
        if ((w_dir != r_prev_dir) || (w_dir == DIR_NONE)) begin
            w_cnt_eff = 4'd0;
        end
        w_cnt_next = (w_cnt_eff >= LP_LAST) ? 4'd0 : (w_cnt_eff + 4'd1);
    end

    // Cadence counter and registered move pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_dir   <= DIR_NONE;
            r_cnt        <= 4'd0;
            r_up_pulse   <= 1'b0;
            r_down_pulse <= 1'b0;
        end else begin
            r_prev_dir   <= w_dir;
            r_up_pulse   <= 1'b0;
            r_down_pulse <= 1'b0;
            if (w_dir == DIR_NONE) begin
                r_cnt <= 4'd0;
            end else if (i_frame_tick) begin
                r_cnt        <= w_cnt_next;
                r_up_pulse   <= (w_dir == DIR_UP)   && (w_cnt_eff == 4'd0);
                r_down_pulse <= (w_dir == DIR_DOWN) && (w_cnt_eff == 4'd0);
            end else begin
                r_cnt <= w_cnt_eff;
            end
        end
    end

    assign o_up_pulse   = r_up_pulse;
    assign o_down_pulse = r_down_pulse;

endmodule

module paddle_key_scheduler #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic       inclock,
    input  logic       resetn,
    input  logic [7:0] ps2_key_data,
    input  logic       ps2_key_pressed,
    input  logic       frame_tick,
    output logic       left_up,
    output logic       left_down,
    output logic       right_up,
    output logic       right_down,
    output logic [3:0] keys_held,
    output logic [7:0] last_ascii,
    output logic       protocol_err,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0] LP_BREAK  = 8'hF0;
    localparam logic [7:0] LP_EXTEND = 8'hE0;

    // Held-vector bit positions: {W,S,I,K} with W in bit 3.
    localparam logic [1:0] LP_BIT_W = 2'd3;
    localparam logic [1:0] LP_BIT_S = 2'd2;
    localparam logic [1:0] LP_BIT_I = 2'd1;
    localparam logic [1:0] LP_BIT_K = 2'd0;

    state_t     r_state;
    logic [3:0] r_held;
    logic [7:0] r_ascii;
    logic       r_err;
    logic       r_left_pri_down;
    logic       r_right_pri_down;

    logic       w_mapped;
    logic [1:0] w_bit;
    logic [7:0] w_ascii;
    logic       w_is_prefix;

    // Scancode lookup: which held bit a byte names and its ASCII letter.
    always_comb begin
        w_mapped = 1'b1;
        w_bit    = LP_BIT_W;
        w_ascii  = 8'h00;
        case (ps2_key_data)
            8'h1D: begin w_bit = LP_BIT_W; w_ascii = 8'd87; end
            8'h1B: begin w_bit = LP_BIT_S; w_ascii = 8'd83; end
            8'h43: begin w_bit = LP_BIT_I; w_ascii = 8'd73; end
            8'h42: begin w_bit = LP_BIT_K; w_ascii = 8'd75; end
            default: w_mapped = 1'b0;
        endcase
        w_is_prefix = (ps2_key_data == LP_BREAK) || (ps2_key_data == LP_EXTEND);
    end

    // Decode FSM: tracks break/extend prefixes and owns the held vector,
    // last ASCII, per-paddle priority and the protocol error pulse.
    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            r_state          <= ST_IDLE;
            r_held           <= 4'b0000;
            r_ascii          <= 8'h20;
            r_err            <= 1'b0;
            r_left_pri_down  <= 1'b0;
            r_right_pri_down <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (ps2_key_pressed) begin
                case (r_state)
                    ST_IDLE: begin
                        if (ps2_key_data == LP_BREAK) begin
                            r_state <= ST_BRK;
                        end else if (ps2_key_data == LP_EXTEND) begin
                            r_state <= ST_EXT;
                        end else if (w_mapped) begin
                            // Makes and typematic repeats both land here.
                            r_held[w_bit] <= 1'b1;
                            r_ascii       <= w_ascii;
                            case (w_bit)
                                LP_BIT_W: r_left_pri_down  <= 1'b0;
                                LP_BIT_S: r_left_pri_down  <= 1'b1;
                                LP_BIT_I: r_right_pri_down <= 1'b0;
                                default:  r_right_pri_down <= 1'b1;
                            endcase
                        end
                    end
                    ST_BRK: begin
                        r_state <= ST_IDLE;
                        if (w_is_prefix) begin
                            r_err <= 1'b1;
                        end else if (w_mapped) begin
                            r_held[w_bit] <= 1'b0;
                        end
                    end
                    ST_EXT: begin
                        // No extended keys are mapped; only track a break.
                        r_state <= (ps2_key_data == LP_BREAK) ? ST_EXT_BRK : ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    paddle_axis #(.TICK_DIV(TICK_DIV)) u_left (
        .i_clk        (inclock),
        .i_rst_n      (resetn),
        .i_frame_tick (frame_tick),
        .i_up_held    (r_held[LP_BIT_W]),
        .i_down_held  (r_held[LP_BIT_S]),
        .i_pri_down   (r_left_pri_down),
        .o_up_pulse   (left_up),
        .o_down_pulse (left_down)
    );

    paddle_axis #(.TICK_DIV(TICK_DIV)) u_right (
        .i_clk        (inclock),
        .i_rst_n      (resetn),
        .i_frame_tick (frame_tick),
        .i_up_held    (r_held[LP_BIT_I]),
        .i_down_held  (r_held[LP_BIT_K]),
        .i_pri_down   (r_right_pri_down),
        .o_up_pulse   (right_up),
        .o_down_pulse (right_down)
    );

    assign keys_held    = r_held;
    assign last_ascii   = r_ascii;
    assign protocol_err = r_err;
    assign dbg_state    = r_state;

endmodule

// File: doc/paddle_key_scheduler.md
PADDLE_KEY_SCHEDULER -- requirements
Module: paddle_key_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4, meaning frame_ticks between successive move pulses while a direction is held (legal 1..15).
REQ-002 SHALL have port inclock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ps2_key_data  input  8  scancode byte from PS/2 controller.
REQ-005 SHALL have port ps2_key_pressed  input  1  one-cycle strobe, ps2_key_data valid.
REQ-006 SHALL have port frame_tick  input  1  one-cycle game-frame strobe.
REQ-007 SHALL have ports left_up, left_down, right_up, right_down  output  1 each  one-cycle paddle move pulses.
REQ-008 SHALL have port keys_held  output  4  held state {W,S,I,K}, bit 3 = W.
REQ-009 SHALL have port last_ascii  output  8  ASCII of last mapped make code.
REQ-010 SHALL have port protocol_err  output  1  one-cycle pulse on malformed prefix sequence.

Function
REQ-011 SHALL map make codes 1D->W/87, 1B->S/83, 43->I/73, 42->K/75; W/S = left up/down, I/K = right up/down; all other codes unmapped.
REQ-012 SHALL run decode FSM with states IDLE, BRK, EXT, EXT_BRK, advancing only on cycles with ps2_key_pressed=1.
REQ-013 IDLE: F0 -> BRK; E0 -> EXT; mapped code -> set held bit, update last_ascii, update paddle priority, stay IDLE; unmapped -> ignore, stay IDLE.
REQ-014 BRK: mapped code -> clear held bit, -> IDLE; unmapped code -> IDLE; F0 or E0 -> protocol_err pulse, -> IDLE, byte discarded.
REQ-015 EXT: F0 -> EXT_BRK; any other byte -> IDLE, discarded (no extended keys mapped).
REQ-016 EXT_BRK: any byte -> IDLE, discarded, held bits unchanged.
REQ-017 keys_held, last_ascii, FSM state SHALL update in cycle N+1 for strobe in cycle N; protocol_err asserted in N+1 for exactly one cycle.
REQ-018 Typematic repeat of a held make SHALL leave held bit 1, rewrite last_ascii, re-assert priority for that key.
REQ-019 Per paddle, direction SHALL be: only up held -> UP; only down held -> DOWN; both held -> most recently made key; neither -> NONE.
REQ-020 Per paddle, 4-bit counter SHALL count frame_ticks mod TICK_DIV while direction is UP or DOWN; move pulse issued on a frame_tick when counter = 0.
REQ-021 Counter SHALL clear to 0 whenever direction becomes NONE or changes UP<->DOWN, so first frame_tick after a new direction yields a pulse.
REQ-022 Move pulse SHALL be registered: frame_tick in cycle N -> pulse high in cycle N+1 only; up and down of one paddle never simultaneously high.
REQ-023 frame_tick and ps2_key_pressed in same cycle: tick SHALL use direction from held state before the key update.
REQ-024 Left and right paddles SHALL be independent; both may pulse in the same cycle.
REQ-025 ps2_key_pressed held high multiple cycles SHALL be treated as one byte per cycle.

Reset
REQ-026 On resetn=0, asynchronously: FSM IDLE, keys_held 0000, last_ascii 8'h20, all move pulses 0, protocol_err 0, counters 0, priority bits 0.
REQ-027 Reset between F0 and following byte SHALL drop the pending break; next 1D after release is a make.
REQ-028 Logic SHALL resume on first rising edge after resetn deasserts.

Verification
REQ-029 Strobe 1D, then 4 frame_ticks, TICK_DIV=4 -> keys_held=1000, last_ascii=87, left_up pulses once (first tick), no other pulses.
REQ-030 Strobe 1D, F0, 1D, then frame_tick -> keys_held 1000 then 0000, no move pulse after break.
REQ-031 Strobe 1D then 1B, frame_tick -> keys_held=1100, left_down pulse (last pressed wins); then F0 1B, frame_tick -> left_up pulse.
REQ-032 Strobe 43 and 1D held, 8 frame_ticks, TICK_DIV=2 -> right_up and left_up each pulse 4 times, concurrently.
REQ-033 Strobe F0, F0 -> protocol_err one-cycle pulse, FSM IDLE; then E0, F0, 42 -> keys_held unchanged, last_ascii unchanged.
REQ-034 Strobe 42, F0, assert resetn=0 mid-run, release, strobe 42 -> keys_held=0001, last_ascii=75, right_down pulse on next frame_tick.
